// File: rtl/cis_pattern_sequencer.sv
// Multi-row CIS/CCD pattern sequencer: plays CCD-reset, integration and skipping column
// patterns onto NUM_SIGNALS lines, row after row. Optional macro: CIS_SEQ_LOOP_EN (loop_en port).
module cis_pattern_sequencer #(
  parameter int NUM_SIGNALS = 11,
  parameter int PATTERN_LEN = 16,
  parameter int CNT_W       = 10,
  parameter int LEN_W       = $clog2(PATTERN_LEN + 1)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    integration,
  input  logic                                    abort,
`ifdef CIS_SEQ_LOOP_EN
  input  logic                                    loop_en,
`endif
  input  logic [CNT_W-1:0]                        clk_div,
  input  logic [CNT_W-1:0]                        skip_samples,
  input  logic [CNT_W-1:0]                        num_rows,
  input  logic [LEN_W-1:0]                        len_ccd_reset,
  input  logic [LEN_W-1:0]                        len_integration,
  input  logic [LEN_W-1:0]                        len_skipping,
  input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_ccd_reset,
  input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_integration,
  input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_skipping,
  input  logic [NUM_SIGNALS-1:0]                  idle_level,
  output logic [NUM_SIGNALS-1:0]                  signal,
  output logic                                    running,
  output logic [1:0]                              phase,
  output logic [CNT_W-1:0]                        skip_count,
  output logic [CNT_W-1:0]                        row_count,
  output logic                                    frame_done
);

  localparam int CIDX_W = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PATTERN_LEN);

  typedef logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pat_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CCD = 2'd1, ST_INTEG = 2'd2, ST_SKIP = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic                   integ_prev_q;
  logic [CNT_W-1:0]       div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]       skip_count_q, skip_count_d;
  logic [CNT_W-1:0]       row_count_q, row_count_d;
  logic [CIDX_W-1:0]      col_q, col_d;
  logic [NUM_SIGNALS-1:0] signal_q, signal_d;
  logic                   running_q, running_d;
  logic                   frame_done_q, frame_done_d;
  logic [CNT_W-1:0]       div_q, div_d, skip_q, skip_d, rows_q, rows_d;
  logic [CIDX_W-1:0]      last_r_q, last_r_d, last_i_q, last_i_d, last_s_q, last_s_d;
  pat_t                   pat_r_q, pat_r_d, pat_i_q, pat_i_d, pat_s_q, pat_s_d;
  logic                   trigger, col_end, row_end, latch_cfg, loop_go;
  logic [CIDX_W-1:0]      cur_last;
  pat_t                   cur_pat;

  // Effective last column index: 0 or out-of-range lengths mean a full pattern.
  function automatic logic [CIDX_W-1:0] last_col_of(input logic [LEN_W-1:0] len);
    if (len == '0 || len > LEN_MAX) return CIDX_W'(PATTERN_LEN - 1);
    return CIDX_W'(len - LEN_W'(1));
  endfunction

  function automatic logic [NUM_SIGNALS-1:0] col_of(input pat_t pat, input logic [CIDX_W-1:0] c);
    logic [NUM_SIGNALS-1:0] v;
    v = '0;
    for (int s = 0; s < NUM_SIGNALS; s++) v[s] = pat[s][c];
    return v;
  endfunction

`ifdef CIS_SEQ_LOOP_EN
  assign loop_go = loop_en;
`else
  assign loop_go = 1'b0;
`endif

  assign trigger = integration && !integ_prev_q;
  assign col_end = (div_cnt_q == div_q - CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    col_d        = col_q;
    skip_count_d = skip_count_q;
    row_count_d  = row_count_q;
    signal_d     = signal_q;
    running_d    = running_q;
    frame_done_d = 1'b0;
    div_d        = div_q;
    skip_d       = skip_q;
    rows_d       = rows_q;
    last_r_d     = last_r_q;
    last_i_d     = last_i_q;
    last_s_d     = last_s_q;
    pat_r_d      = pat_r_q;
    pat_i_d      = pat_i_q;
    pat_s_d      = pat_s_q;
    row_end      = 1'b0;
    latch_cfg    = 1'b0;
    case (state_q)
      ST_CCD:   begin cur_pat = pat_r_q; cur_last = last_r_q; end
      ST_INTEG: begin cur_pat = pat_i_q; cur_last = last_i_q; end
      default:  begin cur_pat = pat_s_q; cur_last = last_s_q; end
    endcase

    if (abort) begin
      state_d      = ST_IDLE;
      signal_d     = idle_level;
      running_d    = 1'b0;
      div_cnt_d    = '0;
      col_d        = '0;
      skip_count_d = '0;
      row_count_d  = '0;
    end else if (state_q == ST_IDLE) begin
      signal_d = idle_level;
      if (trigger) begin
        latch_cfg = 1'b1;
        state_d   = ST_CCD;
        running_d = 1'b1;
        signal_d  = col_of(pattern_ccd_reset, '0);
        div_cnt_d = '0;
        col_d     = '0;
      end
    end else if (!col_end) begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
    end else begin
      div_cnt_d = '0;
      if (col_q != cur_last) begin
        col_d    = col_q + CIDX_W'(1);
        signal_d = col_of(cur_pat, col_q + CIDX_W'(1));
      end else begin
        col_d = '0;
        case (state_q)
          ST_CCD: begin
            state_d  = ST_INTEG;
            signal_d = col_of(pat_i_q, '0);
          end
          ST_INTEG: begin
            if (skip_q != '0) begin
              state_d  = ST_SKIP;
              signal_d = col_of(pat_s_q, '0);
            end else begin
              row_end = 1'b1;
            end
          end
          ST_SKIP: begin
            if (skip_count_q + CNT_W'(1) < skip_q) begin
              skip_count_d = skip_count_q + CNT_W'(1);
              signal_d     = col_of(pat_s_q, '0);
            end else begin
              row_end = 1'b1;
            end
          end
          default: ;
        endcase
        // Row end either starts the next row with no gap or closes the frame.
        if (row_end) begin
          skip_count_d = '0;
          if (row_count_q + CNT_W'(1) < rows_q) begin
            row_count_d = row_count_q + CNT_W'(1);
            state_d     = ST_CCD;
            signal_d    = col_of(pat_r_q, '0);
          end else begin
            row_count_d  = '0;
            frame_done_d = 1'b1;
            if (loop_go) begin
              latch_cfg = 1'b1;
              state_d   = ST_CCD;
              signal_d  = col_of(pattern_ccd_reset, '0);
            end else begin
              state_d   = ST_IDLE;
              running_d = 1'b0;
              signal_d  = idle_level;
            end
          end
        end
      end
    end

    if (latch_cfg) begin
      div_d    = (clk_div == '0) ? CNT_W'(1) : clk_div;
      skip_d   = skip_samples;
      rows_d   = (num_rows == '0) ? CNT_W'(1) : num_rows;
      last_r_d = last_col_of(len_ccd_reset);
      last_i_d = last_col_of(len_integration);
      last_s_d = last_col_of(len_skipping);
      pat_r_d  = pattern_ccd_reset;
      pat_i_d  = pattern_integration;
      pat_s_d  = pattern_skipping;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      integ_prev_q <= 1'b0;
      div_cnt_q    <= '0;
      col_q        <= '0;
      skip_count_q <= '0;
      row_count_q  <= '0;
      signal_q     <= '0;
      running_q    <= 1'b0;
      frame_done_q <= 1'b0;
      div_q        <= '0;
      skip_q       <= '0;
      rows_q       <= '0;
      last_r_q     <= '0;
      last_i_q     <= '0;
      last_s_q     <= '0;
      pat_r_q      <= '0;
      pat_i_q      <= '0;
      pat_s_q      <= '0;
    end else begin
      state_q      <= state_d;
      integ_prev_q <= integration;
      div_cnt_q    <= div_cnt_d;
      col_q        <= col_d;
      skip_count_q <= skip_count_d;
      row_count_q  <= row_count_d;
      signal_q     <= signal_d;
      running_q    <= running_d;
      frame_done_q <= frame_done_d;
      div_q        <= div_d;
      skip_q       <= skip_d;
      rows_q       <= rows_d;
      last_r_q     <= last_r_d;
      last_i_q     <= last_i_d;
      last_s_q     <= last_s_d;
      pat_r_q      <= pat_r_d;
      pat_i_q      <= pat_i_d;
      pat_s_q      <= pat_s_d;
    end
  end

  assign signal     = signal_q;
  assign running    = running_q;
  assign phase      = state_q;
  assign skip_count = skip_count_q;
  assign row_count  = row_count_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/cis_pattern_sequencer.md
Name: cis_pattern_sequencer

Overview:
- Parametrised, multi-row successor to the CIS pattern controller.
- Plays three programmable bit-patterns (CCD reset, integration/transfer, skipping) onto NUM_SIGNALS control lines for the CIS/CCD front end and SPROCKET sampling strobes.
- Each phase has a runtime-programmable length and a shared clock divider; the skip phase repeats a programmable number of times; the whole row sequence repeats for a programmable number of rows per frame.
- Sits between the slow-control register bank and the sensor clock drivers.

Parameters:
NUM_SIGNALS, 11, number of output control lines
PATTERN_LEN, 16, maximum columns per pattern (LSB column played first)
CNT_W, 10, width of clk_div, skip_samples, num_rows and status counters
LEN_W, $clog2(PATTERN_LEN+1), width of per-phase length inputs

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
integration  in  1  frame trigger; rising edge starts a frame
abort  in  1  synchronous abort, returns to IDLE
clk_div  in  CNT_W  clk cycles per pattern column; 0 treated as 1
skip_samples  in  CNT_W  skip-pattern repetitions per row; 0 bypasses SKIP
num_rows  in  CNT_W  rows per frame; 0 treated as 1
len_ccd_reset, len_integration, len_skipping  in  LEN_W each  active columns per phase, 1..PATTERN_LEN; 0 or >PATTERN_LEN treated as PATTERN_LEN
pattern_ccd_reset, pattern_integration, pattern_skipping  in  [NUM_SIGNALS][PATTERN_LEN]  per-signal patterns
idle_level  in  NUM_SIGNALS  value driven on signal while IDLE
signal  out  NUM_SIGNALS  registered control lines
running  out  1  high while a frame is being played
phase  out  2  0=IDLE, 1=CCD_RESET, 2=INTEG, 3=SKIP
skip_count  out  CNT_W  completed skip repetitions in the current row
row_count  out  CNT_W  completed rows in the current frame
frame_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset drives all outputs and internal state to 0: signal=0, running=0, phase=0, skip_count=0, row_count=0, frame_done=0, edge-detect register=0, FSM=IDLE. From the first edge after reset deasserts, IDLE drives signal<=idle_level every cycle.
- Trigger: at a clk edge where integration=1 and the registered previous integration=0, the FSM enters CCD_RESET.
  - On that same edge: running<=1, signal<=column 0 of pattern_ccd_reset.
  - All config inputs (clk_div, skip_samples, num_rows, len_*, patterns) are latched on that edge. Later changes have no effect until the next frame.
- Column timing: a divider counter holds each column for clk_div cycles. At the end of a column, the column index increments. When the index reaches len-1 of the current phase, the next column is column 0 of the next phase.
- Phase order per row: CCD_RESET -> INTEG -> SKIP x skip_samples -> next row or end.
  - skip_count increments at the end of each skip repetition and clears at row start.
  - When skip_samples=0, INTEG goes directly to row end.
- Row end:
  - row_count increments.
  - If row_count+1 < num_rows, go to CCD_RESET column 0 with no gap cycle.
  - Otherwise enter IDLE on that edge: running<=0, frame_done<=1 for one cycle, signal<=idle_level, phase<=0.
- Frame length in cycles = clk_div x (Lr + Li + skip_samples x Ls) x num_rows (effective values after the 0-substitutions above). running is high exactly that many cycles.
- Rising edges of integration while running are ignored, not queued. Another frame needs a new rising edge after IDLE is reached.
- Abort has priority over everything except reset. On the next edge the FSM goes to IDLE: signal<=idle_level, running<=0, counters cleared, no frame_done.
- Reset mid-frame behaves like power-on reset.
- Counters are CNT_W wide and never wrap within a legal frame.

Optional Feature:
CIS_SEQ_LOOP_EN
- Defined: adds input port loop_en (1 bit). At frame end with loop_en=1:
  - frame_done still pulses and row_count clears.
  - The FSM goes directly to CCD_RESET column 0, re-latching config on that edge; running stays high.
  - Deasserting loop_en lets the current frame finish normally.
  - abort stops the loop immediately.
- Not defined: the loop_en port is absent and every frame ends in IDLE.

Test Plan:
- NUM_SIGNALS=11, PATTERN_LEN=12, clk_div=4, all len=12, skip_samples=10, num_rows=1; integration 0->1 -> running high exactly 576 cycles; signal[3] follows pattern_skipping[3] columns, each held 4 cycles; frame_done pulses once as running falls.
- Same config with skip_samples=0, num_rows=3 -> 3 x 96 = 288 running cycles, phase never 3, row_count reads 0,1,2 then clears.
- clk_div=0, len_integration=0, len_ccd_reset=2, skip_samples=1, len_skipping=3 -> treated as clk_div=1, Li=12; frame = 2+12+3 = 17 cycles.
- integration pulsed 0->1->0->1 mid-frame -> second edge ignored; exactly one frame_done; patterns changed mid-frame take effect only on the next frame.
- abort asserted at cycle 100 of a 576-cycle frame -> next edge: signal=idle_level, running=0, phase=0, no frame_done; a subsequent trigger plays a full frame.
- With CIS_SEQ_LOOP_EN, loop_en=1, 576-cycle frame -> frame_done every 576 cycles, running continuously high; clear loop_en -> IDLE after the current frame.
